instr_fetch_unit: RTL and testbench

Instruction fetch sequencer that writes the instruction register over the shared data bus. On a request from the control unit it reads the instruction at the program counter from instruction memory through a req/ack handshake, drives the word onto the bus, and pulses the IR's write enable for exactly one cycle. It then advances the program counter. It owns the program counter and is the sole bus driver during a fetch.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_watchdog.sv | 15 +
 rtl/instr_fetch_unit.sv | 86 ++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, width defaults and reset constants for the fetch unit
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, DRIVE, DONE, ERR} fetch_state_t;
  localparam int IR_WIDTH_DEFAULT = 12;
  localparam int ADDR_WIDTH_DEFAULT = 8;
  localparam int PC_RESET = 0;
  localparam int BUS_RESET = 0;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts REQ cycles without ack and flags the cycle that reaches the limit
module fetch_watchdog #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk) count <= (reset || clear) ? '0 : enable ? count + W'(1) : count;
  assign expired = enable && (count + W'(1) == limit);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the word at pc over req/ack and writes it to the IR via the bus; define FETCH_TIMEOUT_EN for the REQ watchdog
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int IR_width       = IR_WIDTH_DEFAULT,
  parameter int ADDR_width     = ADDR_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_start,
  input  logic                  pc_load,
  input  logic [ADDR_width-1:0] pc_load_value,
  output logic [ADDR_width-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [IR_width-1:0]   mem_rdata,
  output logic [IR_width-1:0]   bus_data,
  output logic                  bus_drive,
  output logic                  ir_write_en,
  output logic                  fetch_done,
  output logic                  fetch_err,
  output logic                  busy,
  output logic [ADDR_width-1:0] pc
);
  fetch_state_t state, state_n;
  logic [ADDR_width-1:0] pc_n;
  logic expired;
  always_comb begin
    state_n = state;
    pc_n = pc;
    case (state)
      IDLE, ERR: begin
        pc_n = pc_load ? pc_load_value : pc;
        state_n = fetch_start ? REQ : state;
      end
      REQ: state_n = mem_ack ? DRIVE : expired ? ERR : REQ;
      DRIVE: begin
        state_n = DONE;
        pc_n = pc + ADDR_width'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= ADDR_width'(PC_RESET);
      mem_addr <= ADDR_width'(PC_RESET);
      mem_req <= 1'b0;
      bus_data <= IR_width'(BUS_RESET);
      bus_drive <= 1'b0;
      ir_write_en <= 1'b0;
      fetch_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      mem_addr <= pc_n;
      mem_req <= state_n == REQ;
      bus_data <= state_n == DRIVE ? mem_rdata : IR_width'(BUS_RESET);
      bus_drive <= state_n == DRIVE;
      ir_write_en <= state_n == DRIVE;
      fetch_done <= state_n == DONE;
      busy <= state_n inside {REQ, DRIVE, DONE};
    end
  end
`ifdef FETCH_TIMEOUT_EN
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  fetch_watchdog #(.W(W)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != REQ),
    .enable (state == REQ && !mem_ack),
    .limit  (W'(TIMEOUT_CYCLES)),
    .expired(expired)
  );
  always_ff @(posedge clk) fetch_err <= reset ? 1'b0 : state_n == ERR;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expired = 1'b0;
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench against a cycle-count model of the fetch sequence
module tb_instr_fetch_unit;
  logic clk = 0, reset = 1, fetch_start = 0, pc_load = 0, mem_ack = 0;
  logic [7:0] pc_load_value = 0;
  logic [11:0] mem_rdata = 0;
  logic [7:0] mem_addr, pc;
  logic [11:0] bus_data;
  logic mem_req, bus_drive, ir_write_en, fetch_done, fetch_err, busy;
  int checks = 0, errors = 0;
  logic [7:0] exp_pc = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_data(bus_data), .bus_drive(bus_drive),
    .ir_write_en(ir_write_en), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .busy(busy), .pc(pc)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task run_fetch(input int delay, input logic [11:0] word, input bit do_load, input logic [7:0] val, input bit noisy);
    fetch_start = 1;
    pc_load = do_load;
    pc_load_value = val;
    if (do_load) exp_pc = val;
    step;
    fetch_start = 0;
    pc_load = 0;
    for (int i = 0; i <= delay; i++) begin
      mem_ack = (i == delay);
      mem_rdata = (i == delay) ? word : 12'($urandom);
      if (noisy) begin
        fetch_start = 1'($urandom);
        pc_load = 1'($urandom);
        pc_load_value = 8'($urandom);
      end
      checks++;
      if ({mem_req, busy, bus_drive, ir_write_en, fetch_err, fetch_done} !== 6'b110000 || mem_addr !== exp_pc)
        begin errors++; $display("FAIL req cycle %0d: req/busy/drv/we/err/done=%b addr=%h exp 110000 addr=%h", i, {mem_req, busy, bus_drive, ir_write_en, fetch_err, fetch_done}, mem_addr, exp_pc); end
      step;
    end
    mem_ack = 0;
    mem_rdata = 12'($urandom);
    if (noisy) begin fetch_start = 1; pc_load = 1; pc_load_value = 8'($urandom); end
    checks++;
    if ({ir_write_en, bus_drive, mem_req, busy, fetch_done} !== 5'b11010 || bus_data !== word || pc !== exp_pc)
      begin errors++; $display("FAIL drive: we/drv/req/busy/done=%b data=%h pc=%h exp 11010 data=%h pc=%h", {ir_write_en, bus_drive, mem_req, busy, fetch_done}, bus_data, pc, word, exp_pc); end
    step;
    exp_pc = exp_pc + 8'd1;
    checks++;
    if ({fetch_done, ir_write_en, bus_drive, mem_req, busy} !== 5'b10001 || bus_data !== 12'h000 || pc !== exp_pc)
      begin errors++; $display("FAIL done: done/we/drv/req/busy=%b data=%h pc=%h exp 10001 data=000 pc=%h", {fetch_done, ir_write_en, bus_drive, mem_req, busy}, bus_data, pc, exp_pc); end
    step;
    fetch_start = 0;
    pc_load = 0;
    checks++;
    if ({fetch_done, busy, mem_req, ir_write_en} !== 4'b0000 || pc !== exp_pc)
      begin errors++; $display("FAIL idle_after: done/busy/req/we=%b pc=%h exp 0000 pc=%h", {fetch_done, busy, mem_req, ir_write_en}, pc, exp_pc); end
  endtask

  task test_reset;
    reset = 1;
    step;
    step;
    reset = 0;
    exp_pc = 0;
    checks++;
    if ({mem_addr, mem_req, bus_data, bus_drive, ir_write_en, fetch_done, fetch_err, busy, pc} !== '0)
      begin errors++; $display("FAIL reset: outputs=%h exp 0", {mem_addr, mem_req, bus_data, bus_drive, ir_write_en, fetch_done, fetch_err, busy, pc}); end
  endtask

  task test_basic;
    run_fetch(0, 12'hA5C, 0, 8'h00, 0);
    checks++;
    if (pc !== 8'h01) begin errors++; $display("FAIL basic_pc: got %h exp 01", pc); end
  endtask

  task test_wrap;
    run_fetch(2, 12'($urandom), 1, 8'hFF, 0);
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h exp 00", pc); end
  endtask

  task test_delay;
    run_fetch(6, 12'h3C7, 0, 8'h00, 0);
    run_fetch(14, 12'h9E1, 0, 8'h00, 0);
  endtask

  task test_ignore;
    run_fetch(3, 12'($urandom), 0, 8'h00, 1);
    step;
    checks++;
    if ({busy, mem_req} !== 2'b00 || pc !== exp_pc)
      begin errors++; $display("FAIL ignore: busy/req=%b pc=%h exp 00 pc=%h", {busy, mem_req}, pc, exp_pc); end
  endtask

  task test_reset_mid;
    fetch_start = 1;
    step;
    fetch_start = 0;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req: got %b exp 1", mem_req); end
    reset = 1;
    step;
    reset = 0;
    mem_ack = 1;
    mem_rdata = 12'($urandom);
    exp_pc = 0;
    checks++;
    if ({mem_addr, mem_req, bus_data, bus_drive, ir_write_en, fetch_done, fetch_err, busy, pc} !== '0)
      begin errors++; $display("FAIL mid_reset: outputs=%h exp 0", {mem_addr, mem_req, bus_data, bus_drive, ir_write_en, fetch_done, fetch_err, busy, pc}); end
    step;
    mem_ack = 0;
    checks++;
    if ({mem_req, bus_data, bus_drive, ir_write_en, fetch_done, busy} !== '0)
      begin errors++; $display("FAIL mid_ack_ignored: outputs=%h exp 0", {mem_req, bus_data, bus_drive, ir_write_en, fetch_done, busy}); end
  endtask

  task test_random;
    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        checks++;
        if ({busy, mem_req, bus_drive, ir_write_en} !== 4'b0000 || pc !== exp_pc)
          begin errors++; $display("FAIL rand_idle: busy/req/drv/we=%b pc=%h exp 0000 pc=%h", {busy, mem_req, bus_drive, ir_write_en}, pc, exp_pc); end
        pc_load = 1'($urandom);
        pc_load_value = 8'($urandom);
        mem_ack = 1'($urandom);
        step;
        if (pc_load) exp_pc = pc_load_value;
      end
      pc_load = 0;
      mem_ack = 0;
      run_fetch($urandom_range(0, 10), 12'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task test_timeout;
    logic [7:0] start_pc;
    start_pc = exp_pc;
    fetch_start = 1;
    step;
    fetch_start = 0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({mem_req, fetch_err} !== 2'b10) begin errors++; $display("FAIL to_req %0d: req/err=%b exp 10", i, {mem_req, fetch_err}); end
      step;
    end
    checks++;
    if ({fetch_err, mem_req, busy} !== 3'b100 || pc !== start_pc)
      begin errors++; $display("FAIL to_err: err/req/busy=%b pc=%h exp 100 pc=%h", {fetch_err, mem_req, busy}, pc, start_pc); end
    step;
    checks++;
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err_hold: got %b exp 1", fetch_err); end
    run_fetch(1, 12'h5A3, 0, 8'h00, 0);
    checks++;
    if (pc !== start_pc + 8'd1) begin errors++; $display("FAIL to_retry_pc: got %h exp %h", pc, start_pc + 8'd1); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_delay;
    test_ignore;
`ifdef FETCH_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
